// File: rtl/mips_run_ctrl_if.sv
// Load/run handshake and core-facing signals of the MIPS run controller.
`timescale 1ns/1ps
interface mips_run_ctrl_if #(
    parameter int unsigned IMEM_WORDS = 256,
    parameter int unsigned CYC_W      = 16
);
    localparam int unsigned LCW = $clog2(IMEM_WORDS) + 1;

    logic              START;
    logic              LD_VALID;
    logic [31:0]       LD_DATA;
    logic              LD_LAST;
    logic              LD_READY;
    logic [31:0]       CPU_PC;
    logic              CPU_RST;
    logic [31:0]       W_Ins;
    logic              WE;
    logic              BUSY;
    logic              DONE;
    logic              HALTED;
    logic              TIMEOUT;
    logic [LCW-1:0]    LOAD_CNT;
    logic [CYC_W-1:0]  CYCLE_CNT;

    // Host/core side: drives the program stream, START and the core PC.
    modport master (
        output START, LD_VALID, LD_DATA, LD_LAST, CPU_PC,
        input  LD_READY, CPU_RST, W_Ins, WE, BUSY, DONE, HALTED, TIMEOUT,
               LOAD_CNT, CYCLE_CNT
    );

    // Controller side.
    modport slave (
        input  START, LD_VALID, LD_DATA, LD_LAST, CPU_PC,
        output LD_READY, CPU_RST, W_Ins, WE, BUSY, DONE, HALTED, TIMEOUT,
               LOAD_CNT, CYCLE_CNT
    );
endinterface

// File: rtl/mips_run_ctrl.sv
// Boot/run sequencer for the single-cycle MIPS core: streams a program into
// instruction memory under reset, runs the core, and reports halt/timeout.
`timescale 1ns/1ps
module mips_run_ctrl #(
    parameter int unsigned IMEM_WORDS  = 256,
    parameter int unsigned CYC_W       = 16,
    parameter int unsigned MAX_CYCLES  = 160,
    parameter int unsigned HALT_REPEAT = 2,
    parameter int unsigned SETTLE_CYC  = 2   // must be >= 1
) (
    input logic            CLK,
    input logic            RST,
    mips_run_ctrl_if.slave bus_io
);
    localparam int unsigned LCW = $clog2(IMEM_WORDS) + 1;
    localparam int unsigned SKW = $clog2(HALT_REPEAT + 1) + 1;
    localparam int unsigned STW = $clog2(SETTLE_CYC + 1) + 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SETTLE,
        ST_RUN,
        ST_FIN
    } state_e;

    state_e           state_q;
    logic             ld_ready_q;
    logic             cpu_rst_q;
    logic             we_q;
    logic [31:0]      w_ins_q;
    logic             busy_q;
    logic             done_q;
    logic             halted_q;
    logic             timeout_q;
    logic [LCW-1:0]   load_cnt_q;
    logic [LCW-1:0]   load_cnt_d;
    logic [CYC_W-1:0] cycle_cnt_q;
    logic [CYC_W-1:0] cycle_cnt_d;
    logic [SKW-1:0]   stuck_q;
    logic [SKW-1:0]   stuck_d;
    logic [STW-1:0]   settle_q;
    logic [31:0]      prev_pc_q;
    logic             pc_vld_q;

    logic             accept_c;
    logic             load_end_c;
    logic             halt_hit_c;
    logic             to_hit_c;

    // Next-value helpers; ld_ready_q is only ever high in LOAD, so accept needs no state term.
    always_comb begin
        accept_c    = bus_io.LD_VALID & ld_ready_q;
        load_cnt_d  = load_cnt_q + LCW'(1);
        load_end_c  = bus_io.LD_LAST | (load_cnt_d == LCW'(IMEM_WORDS));
        cycle_cnt_d = cycle_cnt_q + CYC_W'(1);
        stuck_d     = '0;
        if (pc_vld_q && (bus_io.CPU_PC == prev_pc_q)) begin
            stuck_d = stuck_q + SKW'(1);
        end
        halt_hit_c  = (stuck_d >= SKW'(HALT_REPEAT));
        to_hit_c    = (cycle_cnt_d == CYC_W'(MAX_CYCLES));
    end

    // Sequencer state and all registered outputs.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q     <= ST_IDLE;
            ld_ready_q  <= 1'b0;
            cpu_rst_q   <= 1'b1;
            we_q        <= 1'b0;
            w_ins_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            halted_q    <= 1'b0;
            timeout_q   <= 1'b0;
            load_cnt_q  <= '0;
            cycle_cnt_q <= '0;
            stuck_q     <= '0;
            settle_q    <= '0;
            prev_pc_q   <= '0;
            pc_vld_q    <= 1'b0;
        end else begin
            we_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_FIN: begin
                    if (bus_io.START) begin
                        state_q     <= ST_LOAD;
                        ld_ready_q  <= 1'b1;
                        busy_q      <= 1'b1;
                        done_q      <= 1'b0;
                        load_cnt_q  <= '0;
                        cycle_cnt_q <= '0;
                        halted_q    <= 1'b0;
                        timeout_q   <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (accept_c) begin
                        we_q       <= 1'b1;
                        w_ins_q    <= bus_io.LD_DATA;
                        load_cnt_q <= load_cnt_d;
                        if (load_end_c) begin
                            state_q    <= ST_SETTLE;
                            ld_ready_q <= 1'b0;
                            settle_q   <= '0;
                        end
                    end
                end
                ST_SETTLE: begin
                    if (settle_q == STW'(SETTLE_CYC - 1)) begin
                        state_q   <= ST_RUN;
                        cpu_rst_q <= 1'b0;
                        pc_vld_q  <= 1'b0;
                        stuck_q   <= '0;
                    end else begin
                        settle_q <= settle_q + STW'(1);
                    end
                end
                ST_RUN: begin
                    cycle_cnt_q <= cycle_cnt_d;
                    stuck_q     <= stuck_d;
                    prev_pc_q   <= bus_io.CPU_PC;
                    pc_vld_q    <= 1'b1;
                    if (halt_hit_c || to_hit_c) begin
                        state_q   <= ST_FIN;
                        cpu_rst_q <= 1'b1;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        halted_q  <= halt_hit_c;
                        timeout_q <= to_hit_c;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus_io.LD_READY  = ld_ready_q;
    assign bus_io.CPU_RST   = cpu_rst_q;
    assign bus_io.W_Ins     = w_ins_q;
    assign bus_io.WE        = we_q;
    assign bus_io.BUSY      = busy_q;
    assign bus_io.DONE      = done_q;
    assign bus_io.HALTED    = halted_q;
    assign bus_io.TIMEOUT   = timeout_q;
    assign bus_io.LOAD_CNT  = load_cnt_q;
    assign bus_io.CYCLE_CNT = cycle_cnt_q;
endmodule

// File: tb/tb_mips_run_ctrl.sv
// Bench for mips_run_ctrl: phase-level reference model plus directed scenarios.
`timescale 1ns/1ps
module tb_mips_run_ctrl;
    localparam int unsigned IMEM_WORDS  = 4;
    localparam int unsigned CYC_W       = 16;
    localparam int unsigned MAX_CYCLES  = 160;
    localparam int unsigned HALT_REPEAT = 2;
    localparam int unsigned SETTLE_CYC  = 2;

    localparam int P_IDLE = 0, P_LOAD = 1, P_SETTLE = 2, P_RUN = 3, P_FIN = 4;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    always #5 CLK = ~CLK;

    mips_run_ctrl_if #(.IMEM_WORDS(IMEM_WORDS), .CYC_W(CYC_W)) bus ();

    mips_run_ctrl #(
        .IMEM_WORDS (IMEM_WORDS),
        .CYC_W      (CYC_W),
        .MAX_CYCLES (MAX_CYCLES),
        .HALT_REPEAT(HALT_REPEAT),
        .SETTLE_CYC (SETTLE_CYC)
    ) dut (
        .CLK   (CLK),
        .RST   (RST),
        .bus_io(bus.slave)
    );

    int n_checks = 0;
    int n_errors = 0;

    function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endfunction

    // Core stand-in: PC held at 0 in reset, else advances by 4 (sticks at 0xC for the j-3 program).
    logic [31:0] core_pc = 32'h0;
    bit          halt_prog = 1'b1;
    always @(posedge CLK) begin
        if (bus.CPU_RST !== 1'b0) core_pc <= 32'h0;
        else if (halt_prog && core_pc == 32'hC) core_pc <= core_pc;
        else core_pc <= core_pc + 32'd4;
    end
    assign bus.CPU_PC = core_pc;

    // Reference model: phase + counters, halt taken from the history of observed PCs.
    int          ph;
    bit          m_rdy, m_we, m_halt, m_to;
    logic [31:0] m_wins;
    int          m_lcnt, m_ccnt, settle_left;
    logic [31:0] run_pcs[$];
    bit          mdl_live = 1'b0;

    always @(posedge CLK) begin
        int tr;
        mdl_live = 1'b1;
        if (!RST) begin
            ph = P_IDLE; m_rdy = 0; m_we = 0; m_wins = '0;
            m_lcnt = 0; m_ccnt = 0; m_halt = 0; m_to = 0;
        end else begin
            m_we = 0;
            case (ph)
                P_IDLE, P_FIN: if (bus.START) begin
                    ph = P_LOAD; m_rdy = 1; m_lcnt = 0; m_ccnt = 0; m_halt = 0; m_to = 0;
                end
                P_LOAD: if (bus.LD_VALID && m_rdy) begin
                    m_we = 1; m_wins = bus.LD_DATA; m_lcnt++;
                    if (bus.LD_LAST || m_lcnt == int'(IMEM_WORDS)) begin
                        ph = P_SETTLE; m_rdy = 0; settle_left = int'(SETTLE_CYC);
                    end
                end
                P_SETTLE: begin
                    settle_left--;
                    if (settle_left == 0) begin ph = P_RUN; run_pcs.delete(); end
                end
                P_RUN: begin
                    m_ccnt++;
                    run_pcs.push_back(core_pc);
                    tr = 0;
                    for (int j = run_pcs.size() - 1; j > 0 && run_pcs[j] == run_pcs[j-1]; j--) tr++;
                    m_halt = (tr >= int'(HALT_REPEAT));
                    m_to   = (m_ccnt == int'(MAX_CYCLES));
                    if (m_halt || m_to) ph = P_FIN;
                end
                default: ph = P_IDLE;
            endcase
        end
    end

    // Per-cycle compare, plus a log of every instruction write seen by the core.
    logic [31:0] we_log[$];
    always @(negedge CLK) begin
        if (mdl_live) begin
            check("LD_READY",  32'(bus.LD_READY),  32'(m_rdy));
            check("CPU_RST",   32'(bus.CPU_RST),   32'(ph != P_RUN));
            check("WE",        32'(bus.WE),        32'(m_we));
            check("W_Ins",     bus.W_Ins,          m_wins);
            check("BUSY",      32'(bus.BUSY),      32'(ph == P_LOAD || ph == P_SETTLE || ph == P_RUN));
            check("DONE",      32'(bus.DONE),      32'(ph == P_FIN));
            check("HALTED",    32'(bus.HALTED),    32'(m_halt));
            check("TIMEOUT",   32'(bus.TIMEOUT),   32'(m_to));
            check("LOAD_CNT",  32'(bus.LOAD_CNT),  32'(m_lcnt));
            check("CYCLE_CNT", 32'(bus.CYCLE_CNT), 32'(m_ccnt));
            if (bus.WE === 1'b1) we_log.push_back(bus.W_Ins);
        end
    end

    logic [31:0] prog[8];

    task automatic start_pulse();
        @(negedge CLK); bus.START = 1'b1;
        @(negedge CLK); bus.START = 1'b0;
    endtask

    // Offers n words; once the limit is reached, further offers are counted but not accepted.
    task automatic load_prog(input int n, input bit toggle, input bit use_last,
                             input int max_cyc, output int acc);
        bit v = 1'b0;
        int i = 0;
        acc = 0;
        for (int c = 0; c < max_cyc && i < n; c++) begin
            @(negedge CLK);
            v = toggle ? !v : 1'b1;
            bus.LD_VALID = v;
            bus.LD_DATA  = prog[i];
            bus.LD_LAST  = use_last && (i == n - 1);
            if (v && bus.LD_READY) begin acc++; i++; end
            else if (v && acc >= int'(IMEM_WORDS)) i++;
        end
        @(negedge CLK);
        bus.LD_VALID = 1'b0;
        bus.LD_LAST  = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string nm);
        int c = 0;
        while (bus.DONE !== 1'b1 && c < budget) begin @(negedge CLK); c++; end
        check({nm, "_done_in_budget"}, 32'(bus.DONE === 1'b1), 32'd1);
    endtask

    initial begin
        int acc;
        bus.START = 1'b0; bus.LD_VALID = 1'b0; bus.LD_DATA = '0; bus.LD_LAST = 1'b0;
        RST = 1'b0;
        repeat (3) @(negedge CLK);
        check("rst_cpu_rst",  32'(bus.CPU_RST),   32'd1);
        check("rst_busy",     32'(bus.BUSY),      32'd0);
        check("rst_ld_ready", 32'(bus.LD_READY),  32'd0);
        check("rst_w_ins",    bus.W_Ins,          32'd0);
        RST = 1'b1;

        // Four-word program ending in j 3: the core parks at PC 0xC.
        halt_prog = 1'b1;
        prog[0] = 32'h20080005; prog[1] = 32'h20090007;
        prog[2] = 32'h01095020; prog[3] = 32'h08000003;
        we_log.delete();
        start_pulse();
        load_prog(4, 1'b0, 1'b1, 20, acc);
        check("halt_accepted", 32'(acc), 32'd4);
        wait_done(60, "halt");
        check("halt_halted",  32'(bus.HALTED),    32'd1);
        check("halt_timeout", 32'(bus.TIMEOUT),   32'd0);
        check("halt_cycles",  32'(bus.CYCLE_CNT), 32'd6);
        check("halt_ldcnt",   32'(bus.LOAD_CNT),  32'd4);
        check("halt_we_cnt",  32'(we_log.size()), 32'd4);
        if (we_log.size() == 4) begin
            check("halt_we0", we_log[0], 32'h20080005);
            check("halt_we1", we_log[1], 32'h20090007);
            check("halt_we2", we_log[2], 32'h01095020);
            check("halt_we3", we_log[3], 32'h08000003);
        end

        // Restart from FIN with a one-word program whose PC never sticks.
        halt_prog = 1'b0;
        start_pulse();
        check("restart_halted", 32'(bus.HALTED),    32'd0);
        check("restart_done",   32'(bus.DONE),      32'd0);
        check("restart_cycles", 32'(bus.CYCLE_CNT), 32'd0);
        prog[0] = 32'h00000000;
        load_prog(1, 1'b0, 1'b1, 20, acc);
        check("to_accepted", 32'(acc), 32'd1);
        repeat (10) @(negedge CLK);
        bus.START = 1'b1;
        @(negedge CLK);
        bus.START = 1'b0;
        check("start_in_run_busy", 32'(bus.BUSY), 32'd1);
        wait_done(400, "timeout");
        check("to_timeout", 32'(bus.TIMEOUT),   32'd1);
        check("to_halted",  32'(bus.HALTED),    32'd0);
        check("to_cycles",  32'(bus.CYCLE_CNT), 32'd160);
        @(negedge CLK);
        check("to_cpu_rst_after", 32'(bus.CPU_RST),   32'd1);
        check("to_cycles_hold",   32'(bus.CYCLE_CNT), 32'd160);

        // Six words offered with LD_VALID toggling and no LD_LAST: only four fit.
        halt_prog = 1'b1;
        for (int k = 0; k < 6; k++) prog[k] = 32'hA000_0000 + 32'(k);
        we_log.delete();
        start_pulse();
        load_prog(6, 1'b1, 1'b0, 40, acc);
        check("ovf_accepted", 32'(acc),           32'd4);
        check("ovf_ld_ready", 32'(bus.LD_READY),  32'd0);
        check("ovf_ldcnt",    32'(bus.LOAD_CNT),  32'd4);
        check("ovf_we_cnt",   32'(we_log.size()), 32'd4);
        if (we_log.size() == 4) check("ovf_we3", we_log[3], 32'hA000_0003);
        wait_done(60, "ovf");
        check("ovf_halted", 32'(bus.HALTED), 32'd1);

        // Reset asserted for two cycles in the middle of a run.
        halt_prog = 1'b0;
        start_pulse();
        prog[0] = 32'h00000000;
        load_prog(1, 1'b0, 1'b1, 20, acc);
        repeat (6) @(negedge CLK);
        check("mid_run_active", 32'(bus.CPU_RST), 32'd0);
        RST = 1'b0;
        repeat (2) @(negedge CLK);
        check("mrst_cpu_rst", 32'(bus.CPU_RST),   32'd1);
        check("mrst_we",      32'(bus.WE),        32'd0);
        check("mrst_busy",    32'(bus.BUSY),      32'd0);
        check("mrst_done",    32'(bus.DONE),      32'd0);
        check("mrst_ldcnt",   32'(bus.LOAD_CNT),  32'd0);
        check("mrst_cycles",  32'(bus.CYCLE_CNT), 32'd0);
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        check("idle_busy", 32'(bus.BUSY), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end
endmodule
